countdown_timer: RTL and testbench

- Loadable down-counter that pairs with the free-running up-count seconds timer.
- Software or a front-panel FSM loads a count and starts it. The block then decrements once per SECONDS+1 clock cycles until it reaches zero.
- On reaching zero it raises a one-cycle done pulse and holds an expired flag.
- Sits between the user-input debounce logic and the display/alarm logic.

---
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer.sv | 102 ++++++++++
 tb/tb_countdown_timer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and status bundle for the countdown timer.
// Master (controller) drives start/pause/clear/load_val and observes status.
// Slave (timer) receives the controls and drives count/busy/expired/done.
interface countdown_timer_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             done;

  modport master (
    output start, pause, clear, load_val,
    input  count, busy, expired, done
  );

  modport slave (
    input  start, pause, clear, load_val,
    output count, busy, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter: decrements once per SECONDS+1 cycles, pulses done at zero.
// Latency: all outputs registered; done arrives load_val*(SECONDS+1) run cycles after start.
// No backpressure: start/pause/clear are levels sampled every cycle (clear > start > pause).
module countdown_timer #(
  parameter int SECONDS = 50_000_000,
  parameter int WIDTH   = 10
) (
  input logic             clk,
  input logic             rst,
  countdown_timer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [31:0] PRESC_MAX = SECONDS;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [31:0]      presc_q, presc_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             expired_q;

  // Next-state logic; a PAUSE cycle with pause released advances exactly like
  // RUN so the pause costs precisely as many cycles as pause was held.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (bus.start) begin
      presc_d = '0;
      if (bus.load_val != '0) begin
        count_d = bus.load_val;
        state_d = RUN;
      end else begin
        count_d = '0;
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (presc_q != PRESC_MAX) begin
              presc_d = presc_q + 32'd1;
            end else begin
              presc_d = '0;
              count_d = count_q - WIDTH'(1);
              if (count_q == WIDTH'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // State, count, prescaler and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      busy_q    <= (state_d == RUN) || (state_d == PAUSE);
      expired_q <= (state_d == DONE);
    end
  end

  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with SECONDS=3 (tick every 4 cycles).
// Observed status is packed as {count, busy, expired, done} and compared to hand-derived values.
// Outputs are sampled 1 time unit after the rising edge.
module tb_countdown_timer;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  countdown_timer_if #(.WIDTH(W)) cd ();

  countdown_timer #(.SECONDS(3), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cd.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W+2:0] obs();
    return {cd.count, cd.busy, cd.expired, cd.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cd.start = 1'b0; cd.pause = 1'b0; cd.clear = 1'b0; cd.load_val = '0;
    rst = 1'b0;
    step(); step();
    checks++;
    if (obs() !== {10'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h want=%h", obs(), {10'd0, 3'b000});
    end
    rst = 1'b1;
    step(); step();
    checks++;
    if (obs() !== {10'd0, 3'b000}) begin
      failures++; $display("FAIL idle_hold got=%h want=%h", obs(), {10'd0, 3'b000});
    end
  endtask

  task automatic test_basic_count();
    int pulses;
    logic [W-1:0] ec;
    logic [W+2:0] exp_v;
    cd.load_val = 10'd3; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd3, 3'b100}) begin
      failures++; $display("FAIL basic_load got=%h want=%h", obs(), {10'd3, 3'b100});
    end
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (cd.done === 1'b1) pulses++;
      ec = W'(3 - i / 4);
      exp_v = {ec, (i < 12), (i == 12), (i == 12)};
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL basic_edge%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
    step();
    checks++;
    if (obs() !== {10'd0, 3'b010}) begin
      failures++; $display("FAIL basic_expired_hold got=%h want=%h", obs(), {10'd0, 3'b010});
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL basic_done_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_zero_load();
    cd.load_val = 10'd0; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd0, 3'b011}) begin
      failures++; $display("FAIL zero_load got=%h want=%h", obs(), {10'd0, 3'b011});
    end
    step();
    checks++;
    if (obs() !== {10'd0, 3'b010}) begin
      failures++; $display("FAIL zero_load_after got=%h want=%h", obs(), {10'd0, 3'b010});
    end
  endtask

  task automatic test_pause();
    int done_edge;
    cd.load_val = 10'd2; cd.start = 1'b1;
    step();                       // edge 0, prescaler 0
    cd.start = 1'b0;
    step(); step();               // edges 1,2 -> prescaler 2
    cd.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();                     // edges 3..7 frozen
      checks++;
      if (obs() !== {10'd2, 3'b100}) begin
        failures++; $display("FAIL pause_hold%0d got=%h want=%h", i, obs(), {10'd2, 3'b100});
      end
    end
    cd.pause = 1'b0;
    step();                       // edge 8, prescaler 3
    checks++;
    if (obs() !== {10'd2, 3'b100}) begin
      failures++; $display("FAIL pause_resume1 got=%h want=%h", obs(), {10'd2, 3'b100});
    end
    step();                       // edge 9, tick
    checks++;
    if (obs() !== {10'd1, 3'b100}) begin
      failures++; $display("FAIL pause_resume2 got=%h want=%h", obs(), {10'd1, 3'b100});
    end
    done_edge = 0;
    for (int e = 10; e <= 20; e++) begin
      step();
      if (cd.done === 1'b1 && done_edge == 0) done_edge = e;
    end
    checks++;
    if (done_edge !== 13) begin
      failures++; $display("FAIL pause_total_edges got=%0d want=13", done_edge);
    end
  endtask

  task automatic test_pause_at_tick();
    cd.load_val = 10'd2; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    step(); step(); step();       // prescaler == 3
    cd.pause = 1'b1;
    step(); step();
    checks++;
    if (obs() !== {10'd2, 3'b100}) begin
      failures++; $display("FAIL pause_at_tick_hold got=%h want=%h", obs(), {10'd2, 3'b100});
    end
    cd.pause = 1'b0;
    step();
    checks++;
    if (obs() !== {10'd1, 3'b100}) begin
      failures++; $display("FAIL pause_at_tick_release got=%h want=%h", obs(), {10'd1, 3'b100});
    end
  endtask

  task automatic test_restart_and_clear();
    cd.load_val = 10'd5; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    step(); step();               // prescaler 2, count 5
    cd.load_val = 10'd9; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd9, 3'b100}) begin
      failures++; $display("FAIL restart_load got=%h want=%h", obs(), {10'd9, 3'b100});
    end
    step(); step(); step();
    checks++;
    if (obs() !== {10'd9, 3'b100}) begin
      failures++; $display("FAIL restart_presc_zero got=%h want=%h", obs(), {10'd9, 3'b100});
    end
    step();
    checks++;
    if (obs() !== {10'd8, 3'b100}) begin
      failures++; $display("FAIL restart_first_tick got=%h want=%h", obs(), {10'd8, 3'b100});
    end
    cd.clear = 1'b1; cd.start = 1'b1;
    step();
    cd.clear = 1'b0; cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd0, 3'b000}) begin
      failures++; $display("FAIL clear_over_start got=%h want=%h", obs(), {10'd0, 3'b000});
    end
    step(); step(); step(); step(); step();
    checks++;
    if (obs() !== {10'd0, 3'b000}) begin
      failures++; $display("FAIL clear_stays_idle got=%h want=%h", obs(), {10'd0, 3'b000});
    end
  endtask

  task automatic test_async_reset();
    cd.load_val = 10'd1; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    step(); step();               // prescaler 2, done due at edge 4
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== {10'd0, 3'b000}) begin
      failures++; $display("FAIL async_reset got=%h want=%h", obs(), {10'd0, 3'b000});
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs() !== {10'd0, 3'b000}) begin
        failures++; $display("FAIL post_reset_idle%0d got=%h want=%h", i, obs(), {10'd0, 3'b000});
      end
    end
  endtask

  task automatic test_back_to_back();
    cd.load_val = 10'd1; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (obs() !== {10'd0, 3'b011}) begin
      failures++; $display("FAIL b2b_first_done got=%h want=%h", obs(), {10'd0, 3'b011});
    end
    cd.load_val = 10'd1; cd.start = 1'b1;
    step();
    cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd1, 3'b100}) begin
      failures++; $display("FAIL b2b_restart_from_done got=%h want=%h", obs(), {10'd1, 3'b100});
    end
    step(); step(); step(); step();
    checks++;
    if (obs() !== {10'd0, 3'b011}) begin
      failures++; $display("FAIL b2b_second_done got=%h want=%h", obs(), {10'd0, 3'b011});
    end
    cd.start = 1'b1; cd.load_val = 10'd7;
    step(); step(); step(); step(); step();
    cd.start = 1'b0;
    checks++;
    if (obs() !== {10'd7, 3'b100}) begin
      failures++; $display("FAIL held_start got=%h want=%h", obs(), {10'd7, 3'b100});
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_zero_load();
    test_pause();
    test_pause_at_tick();
    test_restart_and_clear();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
